// File: rtl/us_cache_pkg.sv
// Shared constants and helpers for the upstream timing cache FIFO.
package us_cache_pkg;

  localparam int MODE_STD  = 0;
  localparam int MODE_FWFT = 1;

  // Bit positions inside err_sticky_o
  localparam int ERR_OVF = 0;
  localparam int ERR_UNF = 1;

  function automatic int addrWidth(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/us_cache_fifo_gen_if.sv
// Write/read/status bundle between the timing packer, the FIFO and the DMA/framer.
interface us_cache_fifo_gen_if #(
  parameter int DATA_W = 128,
  parameter int CNT_W  = 12
);

  logic              wr_en_i;
  logic [DATA_W-1:0] din_i;
  logic              full_o;
  logic              prog_full_o;
  logic              rd_en_i;
  logic [DATA_W-1:0] dout_o;
  logic              empty_o;
  logic              prog_empty_o;
  logic [CNT_W-1:0]  prog_full_thresh_i;
  logic [CNT_W-1:0]  prog_empty_thresh_i;
  logic [CNT_W-1:0]  data_count_o;
  logic              overflow_o;
  logic              underflow_o;
  logic              err_clr_i;
  logic [1:0]        err_sticky_o;

  modport master (
    output wr_en_i, din_i, rd_en_i, prog_full_thresh_i, prog_empty_thresh_i, err_clr_i,
    input  full_o, prog_full_o, dout_o, empty_o, prog_empty_o, data_count_o,
           overflow_o, underflow_o, err_sticky_o
  );

  modport slave (
    input  wr_en_i, din_i, rd_en_i, prog_full_thresh_i, prog_empty_thresh_i, err_clr_i,
    output full_o, prog_full_o, dout_o, empty_o, prog_empty_o, data_count_o,
           overflow_o, underflow_o, err_sticky_o
  );

endinterface

// File: rtl/us_cache_sdp_ram.sv
// Simple dual-port RAM with a registered, resettable read port; maps onto block RAM.
module us_cache_sdp_ram #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wrEn,
  input  logic [ADDR_W-1:0] i_wrAddr,
  input  logic [DATA_W-1:0] i_wrData,
  input  logic              i_rdEn,
  input  logic [ADDR_W-1:0] i_rdAddr,
  output logic [DATA_W-1:0] o_rdData
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdData;

  always_ff @(posedge i_clk) begin
    if (i_wrEn) r_mem[i_wrAddr] <= i_wrData;
  end

  // Storage is never cleared; only the read register resets
  always_ff @(posedge i_clk) begin
    if (i_rst)       r_rdData <= '0;
    else if (i_rdEn) r_rdData <= r_mem[i_rdAddr];
  end

  assign o_rdData = r_rdData;

endmodule

// File: rtl/us_cache_fifo_gen.sv
// Single-clock FIFO with standard or first-word-fall-through read, programmable
// thresholds and sticky overflow/underflow flags.
module us_cache_fifo_gen
  import us_cache_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 512,
  parameter int FWFT   = MODE_STD,
  parameter int CNT_W  = 12
) (
  input logic               sys_clk_i,
  input logic               rst_i,
  us_cache_fifo_gen_if.slave bus
);

  localparam int         AW      = addrWidth(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [AW:0]       r_wrPtr, r_rdPtr;
  logic [CNT_W-1:0]  r_count;
  logic              r_full, r_empty, r_progFull, r_progEmpty;
  logic              r_overflow, r_underflow;
  logic [1:0]        r_sticky;
  logic              r_stage1Valid, r_doutValid;
  logic [DATA_W-1:0] r_dout;

  logic [DATA_W-1:0] w_ramData;
  logic              w_wrAcc, w_rdAcc, w_wrRej, w_rdRej;
  logic              w_ramRdEn, w_ld, w_stage1ValidNext, w_doutValidNext;
  logic [CNT_W-1:0]  w_countNext, w_ramOccNext;

  assign w_wrAcc = bus.wr_en_i & ~r_full;
  assign w_rdAcc = bus.rd_en_i & ~r_empty;
  assign w_wrRej = bus.wr_en_i & r_full;
  assign w_rdRej = bus.rd_en_i & r_empty;

  // FWFT keeps the RAM read register (stage 1) primed so a read can be refilled in one cycle
  always_comb begin
    w_ld              = 1'b0;
    w_ramRdEn         = 1'b0;
    w_stage1ValidNext = 1'b0;
    w_doutValidNext   = 1'b0;
    if (FWFT == MODE_FWFT) begin
      w_ld              = (~r_doutValid | w_rdAcc) & r_stage1Valid;
      w_ramRdEn         = (r_wrPtr != r_rdPtr) & (~r_stage1Valid | w_ld);
      w_stage1ValidNext = w_ramRdEn | (r_stage1Valid & ~w_ld);
      w_doutValidNext   = w_ld | (r_doutValid & ~w_rdAcc);
    end else begin
      w_ramRdEn = w_rdAcc;
    end
  end

  // Stage 1 counts as RAM occupancy, so FWFT capacity is DEPTH plus the output word
  always_comb begin
    w_countNext = r_count;
    if (w_wrAcc & ~w_rdAcc)      w_countNext = r_count + CNT_ONE;
    else if (~w_wrAcc & w_rdAcc) w_countNext = r_count - CNT_ONE;
    w_ramOccNext = w_countNext - CNT_W'(w_doutValidNext);
  end

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      r_wrPtr       <= '0;
      r_rdPtr       <= '0;
      r_count       <= '0;
      r_full        <= 1'b0;
      r_empty       <= 1'b1;
      r_progFull    <= 1'b0;
      r_progEmpty   <= 1'b1;
      r_overflow    <= 1'b0;
      r_underflow   <= 1'b0;
      r_sticky      <= '0;
      r_stage1Valid <= 1'b0;
      r_doutValid   <= 1'b0;
      r_dout        <= '0;
    end else begin
      if (w_wrAcc)   r_wrPtr <= r_wrPtr + PTR_ONE;
      if (w_ramRdEn) r_rdPtr <= r_rdPtr + PTR_ONE;
      r_count     <= w_countNext;
      r_full      <= (w_ramOccNext == CNT_W'(DEPTH));
      r_empty     <= (FWFT == MODE_FWFT) ? ~w_doutValidNext : (w_countNext == '0);
      r_progFull  <= (w_countNext >= bus.prog_full_thresh_i);
      r_progEmpty <= (w_countNext <= bus.prog_empty_thresh_i);
      r_overflow  <= w_wrRej;
      r_underflow <= w_rdRej;
      r_sticky[ERR_OVF] <= w_wrRej | (r_sticky[ERR_OVF] & ~bus.err_clr_i);
      r_sticky[ERR_UNF] <= w_rdRej | (r_sticky[ERR_UNF] & ~bus.err_clr_i);
      r_stage1Valid <= w_stage1ValidNext;
      r_doutValid   <= w_doutValidNext;
      if (w_ld) r_dout <= w_ramData;
    end
  end

  us_cache_sdp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (AW)
  ) u_ram (
    .i_clk    (sys_clk_i),
    .i_rst    (rst_i),
    .i_wrEn   (w_wrAcc),
    .i_wrAddr (r_wrPtr[AW-1:0]),
    .i_wrData (bus.din_i),
    .i_rdEn   (w_ramRdEn),
    .i_rdAddr (r_rdPtr[AW-1:0]),
    .o_rdData (w_ramData)
  );

  assign bus.dout_o       = (FWFT == MODE_FWFT) ? r_dout : w_ramData;
  assign bus.full_o       = r_full;
  assign bus.empty_o      = r_empty;
  assign bus.prog_full_o  = r_progFull;
  assign bus.prog_empty_o = r_progEmpty;
  assign bus.data_count_o = r_count;
  assign bus.overflow_o   = r_overflow;
  assign bus.underflow_o  = r_underflow;
  assign bus.err_sticky_o = r_sticky;

endmodule
